// File: rtl/usb_tx_pkg.sv
// Shared types and timing constants for the USB TX bit timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package usb_tx_pkg;

  // Timer state: IDLE between packets, RUN while tx_enable is held high.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tx_state_t;

  // Phase counter width; must hold PERIOD_3BIT.
  localparam int CNT_W = 5;

  // Three bit periods of 8, 8 and 9 clocks fit exactly into 25 clocks,
  // so the strobe falls on these phases of a 1..25 wrapping counter.
  localparam logic [CNT_W-1:0] PHASE_1     = 5'd8;
  localparam logic [CNT_W-1:0] PHASE_2     = 5'd16;
  localparam logic [CNT_W-1:0] PHASE_3     = 5'd25;
  localparam logic [CNT_W-1:0] PERIOD_3BIT = 5'd25;

  // True on the phase that ends a bit period.
  function automatic logic is_strobe_phase(input logic [CNT_W-1:0] c);
    return (c == PHASE_1) || (c == PHASE_2) || (c == PHASE_3);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
// Latency: count_out updates one clock after count_enable; clear wins.
// Backpressure: none; counts whenever count_enable is high.
//
// Ports:
//   clk, n_rst      clock, async active-low reset
//   clear           synchronous clear to 0 (priority over count_enable)
//   count_enable    advance the count this cycle
//   rollover_val    last value before wrapping back to 1
//   count_out       current count
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  // Wrap goes to 1, not 0: 0 only marks "freshly cleared".
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = NUM_CNT_BITS'(1);
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

endmodule

// File: rtl/tx_timer.sv
// USB TX bit timer: bit strobes (8/8/9 clocks), data-shift/byte pulses, byte counter.
// Latency: first bit_strobe 8 clocks after the edge that samples tx_enable high.
// Backpressure: none; stuff_pending only turns a strobe into a non-data slot.
//
// Ports:
//   clk, n_rst      clock, async active-low reset
//   tx_enable       high for the whole packet; low aborts and resets phase
//   stuff_pending   next bit slot is a stuffed bit (no data shift)
//   bit_strobe      1-cycle pulse at end of every bit period
//   shift_data      1-cycle pulse: shift register advances one data bit
//   bit_index       data bit within the current byte, 0..7
//   byte_done       1-cycle pulse on the 8th data shift (next-byte load request)
//   byte_count      bytes completed this packet, saturates at MAX_BYTES
//   byte_overrun    sticky: a byte completed while byte_count was saturated
module tx_timer
  import usb_tx_pkg::*;
#(
  parameter logic [6:0] MAX_BYTES = 7'd69
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_enable,
  input  logic       stuff_pending,
  output logic       bit_strobe,
  output logic       shift_data,
  output logic [2:0] bit_index,
  output logic       byte_done,
  output logic [6:0] byte_count,
  output logic       byte_overrun
);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic             running;
  logic             tx_start;
  logic [2:0]       bit_index_q, bit_index_d;
  logic [6:0]       byte_count_q, byte_count_d;
  logic             overrun_q, overrun_d;

  // ---------------- state machine ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_enable)  state_d = RUN;
      RUN:     if (!tx_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign running  = (state_q == RUN);
  assign tx_start = (state_q == IDLE) & tx_enable;

  // ---------------- phase counter ----------------
  // Counting only starts once in RUN, so cnt sits at 0 for the first RUN
  // cycle and reaches PHASE_1 exactly 8 clocks after the start edge.
  // Clearing on ~tx_enable drops any residual phase on the same edge that
  // leaves RUN.
  assign cnt_clear = ~tx_enable;

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_phase_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (running),
    .rollover_val (PERIOD_3BIT),
    .count_out    (cnt)
  );

  // Gating with tx_enable suppresses a strobe in the cycle tx_enable falls.
  assign bit_strobe = running & tx_enable & is_strobe_phase(cnt);
  assign shift_data = bit_strobe & ~stuff_pending;
  assign byte_done  = shift_data & (bit_index_q == 3'd7);

  // ---------------- bit index ----------------
  // Cleared whenever tx_enable is low, which discards a partial byte.
  always_comb begin
    bit_index_d = bit_index_q;
    if (!tx_enable) begin
      bit_index_d = 3'd0;
    end else if (shift_data) begin
      bit_index_d = bit_index_q + 3'd1;
    end
  end

  // ---------------- byte counter / overrun ----------------
  // Cleared only on packet start; held through IDLE for the controller.
  always_comb begin
    byte_count_d = byte_count_q;
    overrun_d    = overrun_q;
    if (tx_start) begin
      byte_count_d = 7'd0;
      overrun_d    = 1'b0;
    end else if (byte_done) begin
      if (byte_count_q >= MAX_BYTES) begin
        overrun_d = 1'b1;
      end else begin
        byte_count_d = byte_count_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_index_q  <= 3'd0;
      byte_count_q <= 7'd0;
      overrun_q    <= 1'b0;
    end else begin
      bit_index_q  <= bit_index_d;
      byte_count_q <= byte_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bit_index    = bit_index_q;
  assign byte_count   = byte_count_q;
  assign byte_overrun = overrun_q;

endmodule

// File: tb/tb_tx_timer.sv
// Scoreboard bench for tx_timer: stimulus pushes expected strobes and probes,
// a monitor on the falling edge pops and compares them.
// Inputs change 2 time units after the rising edge.
module tb_tx_timer;

  localparam int MAXB = 3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_enable;
  logic       stuff_pending;
  logic       bit_strobe;
  logic       shift_data;
  logic [2:0] bit_index;
  logic       byte_done;
  logic [6:0] byte_count;
  logic       byte_overrun;

  tx_timer #(
    .MAX_BYTES (7'd3)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .tx_enable     (tx_enable),
    .stuff_pending (stuff_pending),
    .bit_strobe    (bit_strobe),
    .shift_data    (shift_data),
    .bit_index     (bit_index),
    .byte_done     (byte_done),
    .byte_count    (byte_count),
    .byte_overrun  (byte_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int shift;
    int bi;
    int bd;
    int bc;
  } sexp_t;

  typedef struct {
    int cyc;
    int tag;
    int bi;
    int bc;
    int ov;
  } pexp_t;

  sexp_t strobe_q[$];
  pexp_t probe_q[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done  = 1'b0;
  int  tag_n = 0;

  // Model state
  int m_bi, m_bc, m_ov;

  // Strobe offsets from the start cycle: 8, 16, 25 repeating every 25.
  function automatic int phase_off(input int k);
    int ph[3];
    ph[0] = 8;
    ph[1] = 16;
    ph[2] = 25;
    return 25 * (k / 3) + ph[k % 3];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_probe(input int at, input int bc, input int ov, input int bi);
    pexp_t p;
    p.cyc = at;
    p.tag = tag_n;
    p.bi  = bi;
    p.bc  = bc;
    p.ov  = ov;
    tag_n++;
    probe_q.push_back(p);
  endtask

  // Expected strobes of one transmission starting at t0, tx_enable low from t0+hold.
  task automatic plan(input int t0, input int hold, input int stuff_k);
    sexp_t e;
    m_bi = 0;
    m_bc = 0;
    m_ov = 0;
    for (int k = 0; phase_off(k) < hold; k++) begin
      e.cyc   = t0 + phase_off(k);
      e.shift = (k != stuff_k) ? 1 : 0;
      e.bi    = m_bi;
      e.bd    = (e.shift == 1 && m_bi == 7) ? 1 : 0;
      e.bc    = m_bc;
      strobe_q.push_back(e);
      if (e.shift == 1) m_bi = (m_bi + 1) % 8;
      if (e.bd == 1) begin
        if (m_bc == MAXB) m_ov = 1;
        else m_bc = m_bc + 1;
      end
    end
  endtask

  task automatic run_tx(input int hold, input int stuff_k, input int idle);
    int t0;
    t0 = cyc + 1;
    push_probe(t0, 0, 0, 0);
    plan(t0, hold, stuff_k);
    tx_enable = 1'b1;
    do begin
      step();
      stuff_pending = (stuff_k >= 0) && (cyc == t0 + phase_off(stuff_k));
    end while (cyc < t0 + hold);
    tx_enable     = 1'b0;
    stuff_pending = 1'b0;
    push_probe(t0 + hold + 2, m_bc, m_ov, 0);
    repeat (idle) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    n_rst         = 1'b0;
    tx_enable     = 1'b0;
    stuff_pending = 1'b0;
    push_probe(2, 0, 0, 0);
    repeat (3) step();
    n_rst = 1'b1;
    repeat (2) step();

    run_tx(100, -1, 5);   // plain: byte_done at +66, one byte
    run_tx(100, 2, 5);    // stuff on 3rd strobe: byte_done at +75
    run_tx(80, 7, 5);     // stuff on what would be the 8th data bit
    run_tx(336, -1, 5);   // 5 bytes, saturate at 3, overrun, held in IDLE

    // reset while idle clears the held counters at once
    n_rst = 1'b0;
    push_probe(cyc, 0, 0, 0);
    step();
    n_rst = 1'b1;
    repeat (2) step();

    run_tx(30, -1, 9);    // drop at +30, re-raise 9 cycles later
    run_tx(60, -1, 5);
    run_tx(16, -1, 5);    // drop exactly on the +16 strobe cycle

    // reset mid-transmission with tx_enable held high
    tx_enable = 1'b1;
    t0 = cyc + 1;
    plan(t0, 20, -1);
    while (cyc < t0 + 20) step();
    n_rst = 1'b0;
    push_probe(cyc, 0, 0, 0);
    repeat (2) step();
    n_rst = 1'b1;
    run_tx(40, -1, 5);

    repeat (3) step();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  initial begin
    sexp_t e;
    pexp_t p;
    forever begin
      @(negedge clk);
      while (strobe_q.size() > 0 && strobe_q[0].cyc < cyc) begin
        e = strobe_q.pop_front();
        chk("missing_strobe", 0, e.cyc);
      end
      if (bit_strobe) begin
        if (strobe_q.size() == 0 || strobe_q[0].cyc != cyc) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = strobe_q.pop_front();
          chk("shift_data", int'(shift_data), e.shift);
          chk("bit_index@strobe", int'(bit_index), e.bi);
          chk("byte_done", int'(byte_done), e.bd);
          chk("byte_count@strobe", int'(byte_count), e.bc);
        end
      end else begin
        chk("pulse_without_strobe", int'({shift_data, byte_done}), 0);
      end
      while (probe_q.size() > 0 && probe_q[0].cyc < cyc) begin
        p = probe_q.pop_front();
        chk("stale_probe", p.tag, -1);
      end
      if (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
        p = probe_q.pop_front();
        chk($sformatf("probe%0d_byte_count", p.tag), int'(byte_count), p.bc);
        chk($sformatf("probe%0d_overrun", p.tag), int'(byte_overrun), p.ov);
        chk($sformatf("probe%0d_bit_index", p.tag), int'(bit_index), p.bi);
      end
      if (done) begin
        chk("strobes_left", strobe_q.size(), 0);
        chk("probes_left", probe_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
